// File: rtl/mgt_01_fsqrt_round_pack.sv
// rtl/mgt_01_fsqrt_round_pack.sv - FSQRT.S round/pack stage with credit-managed 2-entry output FIFO
// Optional: MGT01_FSQRT_ALL_RM_EN enables RTZ/RDN/RUP/RMM; without it rounding is always RNE.
module mgt_01_fsqrt_round_pack #(
    parameter int DATA_WIDTH = 50,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    core_valid_i,
    input  logic [DATA_WIDTH/2-1:0] root_i,
    input  logic [DATA_WIDTH/2:0]   remainder_i,
    input  logic [7:0]              exp_i,
    input  logic [2:0]              rm_i,
    input  logic                    byp_valid_i,
    output logic                    byp_ready_o,
    input  logic [1:0]              byp_class_i,
    input  logic                    byp_sign_i,
    output logic                    issue_ok_o,
    input  logic                    issue_i,
    output logic [31:0]             result_o,
    output logic [4:0]              fflags_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic                    ovf_o
);

    localparam int RW = DATA_WIDTH / 2;
    localparam logic [2:0] DEPTH3 = 3'(FIFO_DEPTH);

    typedef enum logic {
        KIND_CORE = 1'b0,
        KIND_BYP  = 1'b1
    } kind_t;

    // S1 capture register
    logic          s1_valid;
    kind_t         s1_kind;
    logic [RW-1:0] s1_root;
    logic [RW:0]   s1_rem;
    logic [7:0]    s1_exp;
    logic [1:0]    s1_class;
    logic          s1_sign;
`ifdef MGT01_FSQRT_ALL_RM_EN
    logic [2:0]    s1_rm;
`endif

    // credits: used = S1 + FIFO occupancy + reservations; resv = reservations only
    logic [1:0] used;
    logic [1:0] resv;

    logic [36:0] mem [2];
    logic        wr_ptr;
    logic        rd_ptr;
    logic [1:0]  count;

    logic issue_acc;
    logic core_resv;
    logic core_new;
    logic core_acc;
    logic byp_free;
    logic byp_acc;
    logic push;
    logic pop;
    logic [2:0] used_after_issue;

    assign issue_ok_o       = ({1'b0, used} < DEPTH3);
    assign issue_acc        = issue_i && issue_ok_o;
    assign used_after_issue = {1'b0, used} + 3'(issue_acc);

    // a core result normally consumes a reservation; an unreserved one may still take a free slot
    assign core_resv = core_valid_i && (resv != 2'd0);
    assign core_new  = core_valid_i && (resv == 2'd0) && (used_after_issue < DEPTH3);
    assign core_acc  = core_resv || core_new;

    assign byp_free    = (used_after_issue < DEPTH3);
    assign byp_ready_o = rst_n_i && !core_valid_i && byp_free;
    assign byp_acc     = byp_valid_i && byp_ready_o;

    assign out_valid_o = (count != 2'd0);
    assign pop         = out_valid_o && out_ready_i;
    assign push        = s1_valid && ((count < 2'd2) || pop);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            s1_valid <= 1'b0;
            s1_kind  <= KIND_CORE;
            s1_root  <= '0;
            s1_rem   <= '0;
            s1_exp   <= '0;
            s1_class <= '0;
            s1_sign  <= 1'b0;
`ifdef MGT01_FSQRT_ALL_RM_EN
            s1_rm    <= '0;
`endif
        end else begin
            s1_valid <= core_acc || byp_acc;
            if (core_acc) begin
                s1_kind <= KIND_CORE;
                s1_root <= root_i;
                s1_rem  <= remainder_i;
                s1_exp  <= exp_i;
`ifdef MGT01_FSQRT_ALL_RM_EN
                s1_rm   <= rm_i;
`endif
            end else if (byp_acc) begin
                s1_kind  <= KIND_BYP;
                s1_class <= byp_class_i;
                s1_sign  <= byp_sign_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            used  <= '0;
            resv  <= '0;
            ovf_o <= 1'b0;
        end else begin
            used <= used + 2'(issue_acc) + 2'(byp_acc) + 2'(core_new) - 2'(pop);
            resv <= resv + 2'(issue_acc) - 2'(core_resv);
            if (core_valid_i && !core_acc)
                ovf_o <= 1'b1;
        end
    end

    // S2: combinational rounding and special-case packing
    logic          g_bit;
    logic          s_bit;
    logic          l_bit;
    logic          inc;
    logic [RW-1:0] mant;
    logic [7:0]    exp_r;
    logic [22:0]   frac;
    logic [31:0]   s2_result;
    logic [4:0]    s2_flags;

    assign g_bit = s1_root[0];
    assign s_bit = |s1_rem;
    assign l_bit = s1_root[1];

    always_comb begin
        inc = g_bit & (s_bit | l_bit);
`ifdef MGT01_FSQRT_ALL_RM_EN
        case (s1_rm)
            3'b001:  inc = 1'b0;
            3'b010:  inc = 1'b0;
            3'b011:  inc = g_bit | s_bit;
            3'b100:  inc = g_bit;
            default: inc = g_bit & (s_bit | l_bit);
        endcase
`endif
    end

    assign mant  = {1'b0, s1_root[RW-1:1]} + RW'(inc);
    assign exp_r = mant[RW-1] ? s1_exp + 8'd1 : s1_exp;
    assign frac  = mant[RW-1] ? 23'd0 : mant[RW-3:0];

    always_comb begin
        s2_result = 32'd0;
        s2_flags  = 5'd0;
        if (s1_kind == KIND_BYP) begin
            case (s1_class)
                2'b00: begin
                    s2_result = 32'h7FC0_0000;
                    s2_flags  = 5'b10000;
                end
                2'b01:   s2_result = 32'h7FC0_0000;
                2'b10:   s2_result = 32'h7F80_0000;
                default: s2_result = {s1_sign, 31'd0};
            endcase
        end else begin
            s2_result = {1'b0, exp_r, frac};
            s2_flags  = {4'b0000, g_bit | s_bit};
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < 2; i++)
                mem[i] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {s2_result, s2_flags};
                wr_ptr      <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign result_o = mem[rd_ptr][36:5];
    assign fflags_o = mem[rd_ptr][4:0];

    logic unused_bits;
`ifdef MGT01_FSQRT_ALL_RM_EN
    assign unused_bits = mant[RW-2];
`else
    assign unused_bits = mant[RW-2] ^ (^rm_i);
`endif

endmodule

// File: tb/tb_mgt_01_fsqrt_round_pack.sv
// tb/tb_mgt_01_fsqrt_round_pack.sv - directed self-checking bench for mgt_01_fsqrt_round_pack
module tb_mgt_01_fsqrt_round_pack;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        core_valid_i = 1'b0;
    logic [24:0] root_i = '0;
    logic [25:0] remainder_i = '0;
    logic [7:0]  exp_i = '0;
    logic [2:0]  rm_i = '0;
    logic        byp_valid_i = 1'b0;
    logic        byp_ready_o;
    logic [1:0]  byp_class_i = '0;
    logic        byp_sign_i = 1'b0;
    logic        issue_ok_o;
    logic        issue_i = 1'b0;
    logic [31:0] result_o;
    logic [4:0]  fflags_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        ovf_o;

    int n_checks = 0;
    int n_pass   = 0;

    mgt_01_fsqrt_round_pack dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .core_valid_i (core_valid_i),
        .root_i       (root_i),
        .remainder_i  (remainder_i),
        .exp_i        (exp_i),
        .rm_i         (rm_i),
        .byp_valid_i  (byp_valid_i),
        .byp_ready_o  (byp_ready_o),
        .byp_class_i  (byp_class_i),
        .byp_sign_i   (byp_sign_i),
        .issue_ok_o   (issue_ok_o),
        .issue_i      (issue_i),
        .result_o     (result_o),
        .fflags_o     (fflags_o),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .ovf_o        (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic run_core(input logic [24:0] root, input logic [25:0] rem,
                            input logic [7:0] exp, input logic [2:0] rm);
        issue_i = 1'b1;
        tick();
        issue_i = 1'b0;
        root_i = root; remainder_i = rem; exp_i = exp; rm_i = rm;
        core_valid_i = 1'b1;
        tick();
        core_valid_i = 1'b0;
    endtask

    task automatic send_byp(input logic [1:0] cls, input logic sgn);
        byp_class_i = cls; byp_sign_i = sgn;
        byp_valid_i = 1'b1;
        tick();
        byp_valid_i = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [31:0] res, input logic [4:0] flg);
        for (int i = 0; i < 8 && !out_valid_o; i++)
            tick();
        check({tag, "_valid"}, out_valid_o, 1);
        check({tag, "_result"}, result_o, res);
        check({tag, "_fflags"}, fflags_o, flg);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    initial begin
        #2;
        check("rst_result", result_o, 0);
        check("rst_fflags", fflags_o, 0);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_byp_ready", byp_ready_o, 0);
        check("rst_issue_ok", issue_ok_o, 1);
        check("rst_ovf", ovf_o, 0);
        tick();
        rst_n_i = 1'b1;
        tick();
        check("post_rst_byp_ready", byp_ready_o, 1);

        // latency: core_valid at N, out_valid at N+2
        issue_i = 1'b1;
        tick();
        issue_i = 1'b0;
        root_i = 25'h1000000; remainder_i = '0; exp_i = 8'h80; rm_i = 3'b000;
        core_valid_i = 1'b1;
        tick();
        core_valid_i = 1'b0;
        check("lat_n1_valid", out_valid_o, 0);
        tick();
        check("lat_n2_valid", out_valid_o, 1);
        pop_check("sqrt4", 32'h4000_0000, 5'b00000);

        run_core(25'h16A09E6, 26'h1234, 8'h7F, 3'b000);
        pop_check("sqrt2_rne", 32'h3FB5_04F3, 5'b00001);
        run_core(25'h16A09E6, 26'h1234, 8'h7F, 3'b001);
        pop_check("sqrt2_rtz", 32'h3FB5_04F3, 5'b00001);
`ifdef MGT01_FSQRT_ALL_RM_EN
        run_core(25'h16A09E6, 26'h1234, 8'h7F, 3'b011);
        pop_check("sqrt2_rup", 32'h3FB5_04F4, 5'b00001);
        run_core(25'h16A09E6, 26'h1234, 8'h7F, 3'b100);
        pop_check("sqrt2_rmm", 32'h3FB5_04F3, 5'b00001);
        run_core(25'h0000003, 26'h0, 8'h01, 3'b010);
        pop_check("rdn_g_set", 32'h0080_0001, 5'b00001);
        run_core(25'h0000003, 26'h0, 8'h01, 3'b100);
        pop_check("rmm_g_set", 32'h0080_0002, 5'b00001);
`else
        run_core(25'h16A09E6, 26'h1234, 8'h7F, 3'b011);
        pop_check("sqrt2_rup_as_rne", 32'h3FB5_04F3, 5'b00001);
`endif
        run_core(25'h1FFFFFF, 26'h0, 8'h7F, 3'b000);
        pop_check("carry", 32'h4000_0000, 5'b00001);
        // tie at g=1, rem=0, l=0 stays even under RNE
        run_core(25'h1000001, 26'h0, 8'h7F, 3'b000);
        pop_check("tie_even", 32'h3F80_0000, 5'b00001);

        send_byp(2'b00, 1'b0);
        pop_check("byp_nv", 32'h7FC0_0000, 5'b10000);
        send_byp(2'b01, 1'b0);
        pop_check("byp_qnan", 32'h7FC0_0000, 5'b00000);
        send_byp(2'b10, 1'b0);
        pop_check("byp_inf", 32'h7F80_0000, 5'b00000);
        send_byp(2'b11, 1'b1);
        pop_check("byp_negzero", 32'h8000_0000, 5'b00000);

        // core and bypass in the same cycle
        issue_i = 1'b1;
        tick();
        issue_i = 1'b0;
        root_i = 25'h1000000; remainder_i = '0; exp_i = 8'h80;
        core_valid_i = 1'b1;
        byp_class_i = 2'b10; byp_valid_i = 1'b1;
        #1;
        check("arb_byp_blocked", byp_ready_o, 0);
        tick();
        core_valid_i = 1'b0;
        #1;
        check("arb_byp_next", byp_ready_o, 1);
        tick();
        byp_valid_i = 1'b0;
        pop_check("arb_first_core", 32'h4000_0000, 5'b00000);
        pop_check("arb_second_byp", 32'h7F80_0000, 5'b00000);

        // full credits, overflow, order and stability
        issue_i = 1'b1;
        tick();
        tick();
        issue_i = 1'b0;
        check("full_issue_ok", issue_ok_o, 0);
        byp_valid_i = 1'b1;
        #1;
        check("full_byp_ready", byp_ready_o, 0);
        byp_valid_i = 1'b0;
        core_valid_i = 1'b1;
        root_i = 25'h1000000; remainder_i = '0; exp_i = 8'h80;
        tick();
        root_i = 25'h16A09E6; remainder_i = 26'h1; exp_i = 8'h7F;
        tick();
        check("pre_ovf", ovf_o, 0);
        root_i = 25'h1FFFFFF; remainder_i = 26'h0; exp_i = 8'h10;
        tick();
        core_valid_i = 1'b0;
        check("ovf_set", ovf_o, 1);
        tick();
        check("hold_a_result", result_o, 32'h4000_0000);
        tick();
        check("hold_b_result", result_o, 32'h4000_0000);
        check("hold_valid", out_valid_o, 1);
        pop_check("drain_a", 32'h4000_0000, 5'b00000);
        pop_check("drain_b", 32'h3FB5_04F3, 5'b00001);
        check("drain_empty", out_valid_o, 0);
        check("ovf_sticky", ovf_o, 1);
        check("drain_issue_ok", issue_ok_o, 1);

        // asynchronous reset with S1 and FIFO occupied
        issue_i = 1'b1;
        tick();
        issue_i = 1'b0;
        root_i = 25'h1000000; remainder_i = '0; exp_i = 8'h80;
        core_valid_i = 1'b1;
        tick();
        core_valid_i = 1'b0;
        byp_class_i = 2'b10; byp_valid_i = 1'b1;
        tick();
        byp_valid_i = 1'b0;
        check("busy_issue_ok", issue_ok_o, 0);
        rst_n_i = 1'b0;
        #1;
        check("arst_out_valid", out_valid_o, 0);
        check("arst_result", result_o, 0);
        check("arst_fflags", fflags_o, 0);
        check("arst_ovf", ovf_o, 0);
        check("arst_issue_ok", issue_ok_o, 1);
        check("arst_byp_ready", byp_ready_o, 0);
        tick();
        rst_n_i = 1'b1;
        tick();
        check("clean_empty", out_valid_o, 0);
        run_core(25'h1FFFFFF, 26'h0, 8'h7F, 3'b000);
        pop_check("clean_carry", 32'h4000_0000, 5'b00001);
        check("clean_final_empty", out_valid_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
